mod_addition: RTL and testbench
===============================

// Module: mod_addition
// PURPOSE
//  - Multi-cycle 256-bit modular adder: result = (A + B) mod p, for operands already reduced (A, B < p).
//  - Basic field-arithmetic primitive of the ECC datapath.
//  - Callers start it with a level-held start and wait on done.
// PARAMETERS
//  - WIDTH  256  operand, modulus and result width in bits
// PORTS
//  - i_clk    in   1      single clock, rising-edge active
//  - i_rst_n  in   1      asynchronous, active-low reset
//  - i_start  in   1      request; level, may stay high after done
//  - A        in   WIDTH  addend, A < p
//  - B        in   WIDTH  addend, B < p
//  - p        in   WIDTH  modulus
//  - result   out  WIDTH  (A+B) mod p; valid while done=1
//  - done     out  1      completion flag, held high until i_start drops
// BEHAVIOUR
//  - Reset: one clock i_clk; reset i_rst_n is asynchronous and active-low.
//    - While reset is asserted: result=0, done=0, FSM=IDLE, all internal registers cleared.
//    - Reset mid-operation aborts the operation with no partial result.
//  - FSM: IDLE -> ADD -> REDUCE -> DONE.
//    - IDLE: when i_start=1 at a clock edge, latch A, B and p into internal registers, then go to ADD.
//      Inputs are not sampled again until the next acceptance.
//    - ADD: sum[WIDTH:0] = A_r + B_r. The sum is 257 bits wide and keeps the carry. Go to REDUCE.
//    - REDUCE:
//      - if sum >= {1'b0,p_r}, result <= sum - p_r (low WIDTH bits);
//      - otherwise result <= sum[WIDTH-1:0].
//      - The compare is a full 257-bit compare. Go to DONE.
//    - DONE:
//      - done=1, result held stable.
//      - Stay in DONE while i_start=1. Holding i_start high never retriggers an operation.
//      - When i_start=0: clear done to 0, go to IDLE, and keep result at its last value.
//  - Latency: done rises on the 3rd rising edge after the edge on which i_start is accepted.
//  - Registered outputs only; no combinational path from inputs to outputs.
//  - Input changes after acceptance have no effect on the running operation.
//  - Out-of-range operands (A or B >= p): only a single conditional subtraction is performed.
//    - The result is defined as above but is not guaranteed to be < p.
//  - p = 0: result = (A+B) mod 2^WIDTH; no error flag.
//  - i_start going low before done: the operation still completes.
//    - done pulses high for 1 cycle, then the FSM returns to IDLE.
// TESTING
//  - Reset: i_rst_n=0 -> result=0, done=0. Release with i_start=0 -> done stays 0.
//  - No wrap: A=0x123456789, B=0, p=0xfffffffff -> result=0x123456789, done=1.
//  - Wrap: A=0xff, B=0x20, p=0x100 -> result=0x1f.
//  - Large: A=0xdeadbeef, B=0x2152412, p=0xffffffff -> result=0xe0c2e301.
//  - Handshake and exact sum:
//    - A=0x80, B=0x80, p=0x100 -> result=0.
//    - Hold i_start high 50 cycles -> done stays 1, no retrigger.
//    - Drop i_start -> done=0 next edge.
//  - Carry/abort:
//    - A=B=2^256-2, p=2^256-1 -> result=2^256-3 (257-bit carry path).
//    - Pulse i_rst_n low during ADD -> done=0, result=0, FSM back in IDLE.

Source files
------------

// File: rtl/mod_addition.sv
// rtl/mod_addition.sv - multi-cycle WIDTH-bit modular adder, result = (A + B) mod p
//
// Purpose:
//   Field-arithmetic primitive for the ECC datapath. Operands are captured on
//   the accepting edge. The sum is formed with its carry. One conditional
//   subtraction of p then reduces it.
//   Handshake: start is a level. done rises on the third edge after acceptance.
//   done then holds until start drops.
//
// Ports:
//   i_clk    in   1      rising-edge clock
//   i_rst_n  in   1      asynchronous active-low reset
//   i_start  in   1      level request, may stay high after done
//   A        in   WIDTH  addend (expected < p)
//   B        in   WIDTH  addend (expected < p)
//   p        in   WIDTH  modulus (0 means plain wrap-around at 2^WIDTH)
//   result   out  WIDTH  (A + B) mod p, valid while done = 1
//   done     out  1      completion flag
module mod_addition #(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_REDUCE,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] p_r;
  logic [WIDTH:0]   sum_r;

  // The low WIDTH bits of (sum - p) do not depend on sum's carry bit.
  // The carry bit only takes part in the full-width compare below.
  logic [WIDTH-1:0] diff;
  logic             sum_ge_p;

  assign diff     = sum_r[WIDTH-1:0] - p_r;
  assign sum_ge_p = (sum_r >= {1'b0, p_r});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= S_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      p_r    <= '0;
      sum_r  <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (i_start) begin
            a_r   <= A;
            b_r   <= B;
            p_r   <= p;
            state <= S_ADD;
          end
        end

        S_ADD: begin
          sum_r <= {1'b0, a_r} + {1'b0, b_r};
          state <= S_REDUCE;
        end

        S_REDUCE: begin
          result <= sum_ge_p ? diff : sum_r[WIDTH-1:0];
          state  <= S_DONE;
        end

        S_DONE: begin
          // The first cycle in DONE raises the flag. This gives a one-cycle
          // pulse even when start was dropped early. Afterwards the flag holds
          // until start is low. Holding start high never re-enters IDLE, so the
          // block cannot retrigger.
          if (!done) begin
            done <= 1'b1;
          end else if (!i_start) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_addition.sv
// tb/tb_mod_addition.sv - self-checking bench for mod_addition
module tb_mod_addition;

  localparam int W = 256;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] p;
  logic [W-1:0] result;
  logic         done;

  int tests = 0;
  int fails = 0;

  mod_addition #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .A       (a),
    .B       (b),
    .p       (p),
    .result  (result),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic [W-1:0] rand256();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W / 32; i++) r = {r[W-33:0], 32'($urandom())};
    return r;
  endfunction

  // Reference model.
  // In-range operands use a true modulo of the exact sum.
  // Other operands get one subtraction of p when the exact sum reaches p.
  function automatic logic [W-1:0] model(input logic [W-1:0] ma, mb, mp);
    logic [W:0] s;
    s = {1'b0, ma} + {1'b0, mb};
    if (mp != 0 && ma < mp && mb < mp) return W'(s % {1'b0, mp});
    if (s >= {1'b0, mp}) return W'(s - {1'b0, mp});
    return W'(s);
  endfunction

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Issue one operation.
  // Scramble the inputs after acceptance.
  // Measure latency, hold start for `hold` cycles, then release start.
  task automatic run_op(input logic [W-1:0] ta, tb_, tp, expv, input int hold, input string tag);
    int cyc;
    @(negedge clk);
    a = ta; b = tb_; p = tp; start = 1'b1;
    @(posedge clk); #1;
    check({tag, " done low at accept"}, done, 0);
    a = rand256(); b = rand256(); p = rand256();
    cyc = 0;
    while (!done && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, cyc, 3);
    check({tag, " done"}, done, 1);
    check({tag, " result"}, result, expv);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      check({tag, " done held"}, done, 1);
      check({tag, " result held"}, result, expv);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, " done cleared"}, done, 0);
    check({tag, " result kept"}, result, expv);
  endtask

  initial begin
    logic [W-1:0] big_m1;
    logic [W-1:0] big_m2;
    logic [W-1:0] big_m3;
    logic [W-1:0] ra, rb, rp;
    int           cyc;

    big_m1 = {W{1'b1}};
    big_m2 = big_m1 - 1;
    big_m3 = big_m1 - 2;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; p = '0;
    #1;
    check("reset result", result, 0);
    check("reset done", done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle after release done", done, 0);

    run_op(256'h123456789, 256'h0, 256'hfffffffff, 256'h123456789, 0, "no_wrap");
    run_op(256'hff, 256'h20, 256'h100, 256'h1f, 0, "wrap");
    run_op(256'hdeadbeef, 256'h2152412, 256'hffffffff, 256'he0c2e301, 0, "large");
    run_op(256'h80, 256'h80, 256'h100, 256'h0, 50, "exact_sum_hold");
    run_op(big_m2, big_m2, big_m1, big_m3, 0, "carry");
    run_op(big_m1, 256'h5, 256'h0, 256'h4, 0, "p_zero");

    // Drop start right after acceptance: done must still pulse for one cycle.
    @(negedge clk);
    a = 256'h7; b = 256'h9; p = 256'hb; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    #1;
    while (!done && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("early drop latency", cyc, 3);
    check("early drop result", result, 256'h5);
    @(posedge clk); #1;
    check("early drop pulse ends", done, 0);

    // Random in-range operands.
    for (int i = 0; i < 8; i++) begin
      rp = rand256();
      if (rp == 0) rp = 256'h1;
      ra = rand256() % rp;
      rb = rand256() % rp;
      run_op(ra, rb, rp, model(ra, rb, rp), i % 3, $sformatf("rand%0d", i));
    end

    // Random out-of-range operands with a narrow modulus.
    for (int i = 0; i < 4; i++) begin
      ra = rand256();
      rb = rand256();
      rp = {128'h0, rand256() >> 128};
      run_op(ra, rb, rp, model(ra, rb, rp), 0, $sformatf("oor%0d", i));
    end

    // Reset during ADD aborts the operation and clears everything.
    @(negedge clk);
    a = big_m2; b = big_m2; p = big_m1; start = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort done", done, 0);
    check("abort result", result, 0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort stays idle done", done, 0);
    check("abort stays idle result", result, 0);
    run_op(256'h3, 256'h4, 256'h5, 256'h2, 0, "after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
